// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-addressable big-endian data memory.
// Optional bounds checking is enabled by defining DATA_MEMORY_BOUNDS_CHECK_EN.
package data_memory_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned HALF_BYTES = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LANES      = WORD_BYTES;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } access_size_e;

  // Byte wins over half-word when both are asserted.
  function automatic access_size_e decode_size(logic byte_access, logic half_word);
    if (byte_access) begin
      return SZ_BYTE;
    end else if (half_word) begin
      return SZ_HALF;
    end
    return SZ_WORD;
  endfunction

  function automatic int unsigned size_bytes(access_size_e size);
    case (size)
      SZ_BYTE: return 1;
      SZ_HALF: return HALF_BYTES;
      default: return WORD_BYTES;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// Combinational load formatter: places fetched bytes in the result and
// applies sign or zero extension for byte and half-word loads.
module data_memory_load_align
  import data_memory_pkg::*;
(
  input  logic [0:LANES-1][0:BYTE_W-1] lanes,
  input  access_size_e                 size,
  input  logic                         sign_extend,
  output logic [0:31]                  data_out
);

  logic ext;

  // lanes[0] is the lowest address, so its bit 0 is the sign bit.
  assign ext = sign_extend & lanes[0][0];

  always_comb begin
    data_out = '0;
    case (size)
      SZ_BYTE: data_out = {{24{ext}}, lanes[0]};
      SZ_HALF: data_out = {{16{ext}}, lanes[0], lanes[1]};
      default: data_out = lanes;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable big-endian data memory: combinational loads, stores on the
// rising clock edge. Define DATA_MEMORY_BOUNDS_CHECK_EN to reject wrapping accesses.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int unsigned SIZE = 16384
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] addr,
  input  logic [0:31] data_in,
  input  logic        write_enable,
  input  logic        byte_access,
  input  logic        half_word,
  input  logic        sign_extend,
  output logic [0:31] data_out
);

  localparam int unsigned AW = $clog2(SIZE);

  logic [0:BYTE_W-1] mem [SIZE];

  access_size_e                 size;
  logic [AW-1:0]                base;
  logic [AW-1:0]                idx [LANES];
  logic [0:LANES-1][0:BYTE_W-1] lanes;
  logic [0:31]                  aligned;
  logic                         in_range;
  logic                         store_en;

  assign size = decode_size(byte_access, half_word);
  assign base = addr[32-AW +: AW];

  // Lane indices wrap naturally at the top of memory via AW-bit arithmetic.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      idx[k]   = base + AW'(k);
      lanes[k] = mem[idx[k]];
    end
  end

  data_memory_load_align u_load_align (
    .lanes       (lanes),
    .size        (size),
    .sign_extend (sign_extend),
    .data_out    (aligned)
  );

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic [32:0] last_byte;

  assign last_byte = {1'b0, addr} + 33'(size_bytes(size) - 1);
  assign in_range  = ({1'b0, addr} < 33'(SIZE)) && (last_byte < 33'(SIZE));
  assign data_out  = in_range ? aligned : 32'h0;
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^addr[0:31-AW];
  assign in_range       = 1'b1;
  assign data_out       = aligned;
`endif

  assign store_en = write_enable && !reset && in_range;

  always_ff @(posedge clock) begin
    if (store_en) begin
      case (size)
        SZ_BYTE: mem[idx[0]] <= data_in[24:31];
        SZ_HALF: begin
          mem[idx[0]] <= data_in[16:23];
          mem[idx[1]] <= data_in[24:31];
        end
        default: begin
          for (int k = 0; k < LANES; k++) begin
            mem[idx[k]] <= data_in[BYTE_W*k +: BYTE_W];
          end
        end
      endcase
    end
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    if (write_enable && !reset && !in_range) begin
      $warning("data_memory: out-of-range store ignored at addr 0x%08h", addr);
    end
`endif
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
module tb_data_memory;
  localparam int unsigned SIZE = 16384;

  logic        clock = 1'b0;
  logic        reset;
  logic [0:31] addr;
  logic [0:31] data_in;
  logic        write_enable;
  logic        byte_access;
  logic        half_word;
  logic        sign_extend;
  logic [0:31] data_out;

  int errors = 0;
  int checks = 0;

  data_memory #(.SIZE(SIZE)) dut (
    .clock        (clock),
    .reset        (reset),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .byte_access  (byte_access),
    .half_word    (half_word),
    .sign_extend  (sign_extend),
    .data_out     (data_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] exp);
    checks++;
    assert (data_out === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, data_out, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic b, input logic h, input logic se);
    write_enable = 1'b0;
    addr         = a;
    byte_access  = b;
    half_word    = h;
    sign_extend  = se;
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b,
                       input logic h);
    @(negedge clock);
    addr         = a;
    data_in      = d;
    byte_access  = b;
    half_word    = h;
    sign_extend  = 1'b0;
    write_enable = 1'b1;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    addr         = '0;
    data_in      = '0;
    write_enable = 1'b0;
    byte_access  = 1'b0;
    half_word    = 1'b0;
    sign_extend  = 1'b0;

    dut.mem[0] = 8'hDE; dut.mem[1] = 8'hAD; dut.mem[2] = 8'hBE; dut.mem[3] = 8'hEF;
    dut.mem[4] = 8'h55;
    load(32'h0, 1'b0, 1'b0, 1'b0);
    check("reset_word_load", 32'hDEADBEEF);

    // Store while reset is high must be dropped.
    store(32'h0, 32'h12345678, 1'b0, 1'b0);
    load(32'h0, 1'b0, 1'b0, 1'b0);
    check("store_in_reset", 32'hDEADBEEF);
    reset = 1'b0;

    store(32'h100, 32'h11223344, 1'b0, 1'b0);
    load(32'h100, 1'b0, 1'b0, 1'b0); check("word_rt", 32'h11223344);
    load(32'h100, 1'b1, 1'b0, 1'b0); check("byte_100", 32'h00000011);
    load(32'h101, 1'b1, 1'b0, 1'b0); check("byte_101", 32'h00000022);
    load(32'h102, 1'b1, 1'b0, 1'b0); check("byte_102", 32'h00000033);
    load(32'h103, 1'b1, 1'b0, 1'b0); check("byte_103", 32'h00000044);

    dut.mem[32'h20] = 8'hF0; dut.mem[32'h21] = 8'h80;
    dut.mem[32'h22] = 8'h01; dut.mem[32'h23] = 8'h02;
    load(32'h20, 1'b1, 1'b0, 1'b1); check("byte_sext", 32'hFFFFFFF0);
    load(32'h20, 1'b1, 1'b0, 1'b0); check("byte_zext", 32'h000000F0);
    load(32'h20, 1'b0, 1'b1, 1'b1); check("half_sext", 32'hFFFFF080);
    load(32'h20, 1'b0, 1'b1, 1'b0); check("half_zext", 32'h0000F080);
    load(32'h20, 1'b0, 1'b0, 1'b1); check("word_sext_noop", 32'hF0800102);

    store(32'h40, 32'hAABBCCDD, 1'b0, 1'b0);
    store(32'h42, 32'h00001234, 1'b0, 1'b1);
    load(32'h40, 1'b0, 1'b0, 1'b0); check("half_store", 32'hAABB1234);
    store(32'h40, 32'h00000099, 1'b1, 1'b0);
    load(32'h40, 1'b0, 1'b0, 1'b0); check("byte_store", 32'h99BB1234);
    load(32'h41, 1'b0, 1'b1, 1'b0); check("mis_half_zext", 32'h0000BB12);
    load(32'h41, 1'b0, 1'b1, 1'b1); check("mis_half_sext", 32'hFFFFBB12);

    dut.mem[32'h80] = 8'h00; dut.mem[32'h81] = 8'h11;
    dut.mem[32'h82] = 8'h22; dut.mem[32'h83] = 8'h33;
    store(32'h80, 32'h0000CAFE, 1'b1, 1'b1);
    load(32'h80, 1'b0, 1'b0, 1'b0); check("byte_precedence", 32'hFE112233);

    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    load(32'h40, 1'b0, 1'b0, 1'b0); check("survive_reset", 32'h99BB1234);

    // Read during write: old data before the edge, new data after.
    @(negedge clock);
    addr = 32'h100; data_in = 32'h55667788; byte_access = 1'b0; half_word = 1'b0;
    write_enable = 1'b1;
    #1; check("rdw_before", 32'h11223344);
    @(posedge clock); #1;
    write_enable = 1'b0;
    check("rdw_after", 32'h55667788);

`ifndef DATA_MEMORY_BOUNDS_CHECK_EN
    store(SIZE - 2, 32'h01020304, 1'b0, 1'b0);
    load(SIZE - 2, 1'b1, 1'b0, 1'b0); check("wrap_b0", 32'h00000001);
    load(SIZE - 1, 1'b1, 1'b0, 1'b0); check("wrap_b1", 32'h00000002);
    load(32'h0, 1'b1, 1'b0, 1'b0);    check("wrap_b2", 32'h00000003);
    load(32'h1, 1'b1, 1'b0, 1'b0);    check("wrap_b3", 32'h00000004);
    load(SIZE + 1, 1'b0, 1'b0, 1'b0); check("alias_word", 32'h04BEEF55);
`else
    dut.mem[SIZE-4] = 8'h10; dut.mem[SIZE-3] = 8'h20;
    dut.mem[SIZE-2] = 8'h30; dut.mem[SIZE-1] = 8'h7E;
    load(SIZE - 4, 1'b0, 1'b0, 1'b0); check("top_word_ok", 32'h1020307E);
    load(SIZE - 1, 1'b1, 1'b0, 1'b0); check("top_byte_ok", 32'h0000007E);
    load(SIZE - 2, 1'b0, 1'b0, 1'b0); check("oob_word_load", 32'h00000000);
    load(SIZE - 1, 1'b0, 1'b1, 1'b0); check("oob_half_load", 32'h00000000);
    store(SIZE, 32'hA5A5A5A5, 1'b0, 1'b0);
    load(32'h0, 1'b0, 1'b0, 1'b0);    check("oob_store_ignored", 32'hDEADBEEF);
    store(SIZE - 2, 32'hA5A5A5A5, 1'b0, 1'b0);
    load(SIZE - 4, 1'b0, 1'b0, 1'b0); check("oob_store_top", 32'h1020307E);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable, big-endian data memory for the single-cycle processor. Serves word, half-word and byte loads combinationally and commits stores on the rising clock edge. Sits on the processor's data-memory port; the bench preloads it by writing its storage array directly.

## Interface
- SIZE, 16384: capacity in bytes; power of two, at least 4; readable hierarchically as `SIZE`.
- clock  in  1  single system clock; stores commit on its rising edge.
- reset  in  1  synchronous, active-high; blocks stores while high, never clears contents.
- addr  in  [0:31]  byte address; bit 0 is the MSB.
- data_in  in  [0:31]  store data, right-justified for byte and half-word stores.
- write_enable  in  1  store request, sampled at the rising clock edge.
- byte  in  1  byte access.
- half_word  in  1  half-word access, used only when byte is low.
- sign_extend  in  1  sign-extend narrow loads; zero-extend when low.
- data_out  out  [0:31]  load data, combinational.
- Storage array `mem`: SIZE entries of 8 bits, index 0..SIZE-1, reachable hierarchically for preload and dump.

## Operation
- Index a = addr mod SIZE. Byte k of an access uses (a+k) mod SIZE, so accesses wrap at the top of memory.
- Access size: byte=1 selects byte; else half_word=1 selects half; else word. If byte and half_word are both high, the access is a byte access.
- Big-endian: the lowest address holds the most significant byte.
- Word load: data_out = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Half load: data_out[16:31] = {mem[a], mem[a+1]}. Bits [0:15] are copies of mem[a][0] when sign_extend=1, else zero.
- Byte load: data_out[24:31] = mem[a]. Bits [0:23] are copies of mem[a][0] when sign_extend=1, else zero.
- sign_extend has no effect on word loads.
- Word store: mem[a..a+3] ← data_in[0:7], [8:15], [16:23], [24:31].
- Half store: mem[a] ← data_in[16:23], mem[a+1] ← data_in[24:31].
- Byte store: mem[a] ← data_in[24:31].
- A store modifies only its addressed bytes.
- No alignment requirement: misaligned half and word accesses are legal.
- A store happens only when write_enable=1 and reset=0 at the edge.
- X or Z on addr produces X on data_out. Contents are not altered unless a store occurs.

## Timing
- Load latency is zero: data_out follows addr, the size controls, sign_extend and mem combinationally within the same cycle.
- Store latency is one edge: new contents are visible on data_out immediately after the storing edge.
- Read during write to the same address: data_out shows the old data before the edge and the new data after it.
- Reset: no output register exists, so data_out always reflects memory. Storage persists across reset. A store asserted in a reset cycle is dropped.
- No handshake; every access completes in one cycle.

## Configuration
- DATA_MEMORY_BOUNDS_CHECK_EN defined:
  - An access is out of range when addr ≥ SIZE, or when addr + access width − 1 ≥ SIZE.
  - Out-of-range loads return 32'h0.
  - Out-of-range stores are ignored and print a simulation warning with the address.
- DATA_MEMORY_BOUNDS_CHECK_EN undefined: modulo wrap as described in Operation; no warning.

## Structure
- Package data_memory_pkg holds:
  - the access-size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the function decoding byte/half_word to that enum;
  - byte-lane width constants.
- Sub-module data_memory_load_align: takes the four fetched bytes, the access size and sign_extend, and produces data_out. It is pure combinational logic.
- Top level keeps `mem`, the address wrap, store commit and the bounds check.

## Test plan
- Word round trip: store 32'h11223344 at addr 0x100, then word load at 0x100 → 32'h11223344. Byte loads at 0x100..0x103 → 0x11, 0x22, 0x33, 0x44.
- Narrow extension: preload mem[0x20]=8'hF0, mem[0x21]=8'h80.
  - Byte load, sign_extend=1 → 32'hFFFFFFF0; sign_extend=0 → 32'h000000F0.
  - Half load, sign_extend=1 → 32'hFFFFF080; sign_extend=0 → 32'h0000F080.
- Partial store: word at 0x40 = 32'hAABBCCDD. Half store 32'h00001234 at 0x42 → word reads 32'hAABB1234. Byte store 32'h99 at 0x40 → word reads 32'h99BB1234.
- Precedence and reset:
  - byte=1 and half_word=1, store 32'hCAFE at 0x80 → only mem[0x80]=8'hFE changes.
  - Word store with reset=1 → contents unchanged.
  - Preloaded contents survive a reset pulse.
- Wrap and misalignment, check macro off:
  - Word store 32'h01020304 at SIZE-2 → mem[SIZE-2]=01, mem[SIZE-1]=02, mem[0]=03, mem[1]=04.
  - Word load at addr SIZE+1 returns mem[1..4].
- Bounds, with DATA_MEMORY_BOUNDS_CHECK_EN:
  - Word load at SIZE-2 → 32'h0.
  - Store at SIZE → no change, and a warning is printed.
